nts_engine_selector: RTL and testbench

//  Picks which NTS/mini engine receives each classified RX frame. Replaces the fixed busy/ready steering

---
 rtl/nts_engine_selector_pkg.sv | 27 ++
 rtl/nts_engine_selector_rr_arbiter.sv | 31 +++
 rtl/nts_engine_selector.sv | 221 ++++++++++++++++++++++
 tb/tb_nts_engine_selector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_engine_selector_pkg.sv
// Shared encodings for the NTS engine selector: frame classes, FSM states
// and statistics window offsets.
package nts_engine_selector_pkg;

    typedef enum logic [1:0] {
        CLS_NTS      = 2'd0,
        CLS_NTP_AUTH = 2'd1,
        CLS_NTP      = 2'd2,
        CLS_NET      = 2'd3
    } pkt_class_e;

    localparam int NUM_CLASSES = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    localparam logic [5:0] STATS_OFS_GRANT = 6'h00;
    localparam logic [5:0] STATS_OFS_DROP  = 6'h10;
    localparam logic [5:0] STATS_OFS_CLEAR = 6'h20;

    // NTS and plain NTP need a full engine; everything else goes to mini engines.
    function automatic logic class_uses_nts(input logic [1:0] cls);
        return (cls == CLS_NTS) || (cls == CLS_NTP);
    endfunction

endpackage

// File: rtl/nts_engine_selector_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping, returned as one-hot grant plus index.
module nts_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int cand;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(i_ptr) + off) % N;
            if (!o_any && i_req[cand]) begin
                o_any       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/nts_engine_selector.sv
// Class-aware round-robin steering of classified RX frames onto NTS / mini engines,
// with wait timeout and drop pulse. Optional stats window: NTS_ENGINE_SELECTOR_STATS_EN.
module nts_engine_selector
    import nts_engine_selector_pkg::*;
#(
    parameter int                        ENGINES_NTS    = 2,
    parameter int                        ENGINES_MINI   = 2,
    parameter int                        WAIT_CYCLES    = 1024,
    parameter int                        CNT_WIDTH      = 32,
    parameter int                        API_ADDR_WIDTH = 12,
    parameter int                        API_RW_WIDTH   = 32,
    parameter logic [API_ADDR_WIDTH-1:0] API_BASE       = 12'h300
) (
    input  logic                                 i_clk,
    input  logic                                 i_areset,
    input  logic                                 i_pkt_valid,
    input  logic [1:0]                           i_pkt_class,
    output logic                                 o_pkt_ready,
    output logic                                 o_pkt_drop,
    input  logic [ENGINES_NTS+ENGINES_MINI-1:0]  i_engine_busy,
    input  logic [ENGINES_NTS+ENGINES_MINI-1:0]  i_engine_ready,
    output logic                                 o_grant_valid,
    output logic [ENGINES_NTS+ENGINES_MINI-1:0]  o_grant,
    input  logic                                 i_grant_done,
    input  logic                                 i_api_cs,
    input  logic                                 i_api_we,
    input  logic [API_ADDR_WIDTH-1:0]            i_api_address,
    input  logic [API_RW_WIDTH-1:0]              i_api_write_data,
    output logic [API_RW_WIDTH-1:0]              o_api_read_data
);

    localparam int ENGINES = ENGINES_NTS + ENGINES_MINI;
    localparam int IDX_W   = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int WAIT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         cls_q, cls_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ENGINES-1:0] grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic               drop_q, drop_d;

    logic [ENGINES-1:0] support;
    logic [ENGINES-1:0] eligible;
    logic [ENGINES-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               grant_evt;
    logic               drop_evt;

    always_comb begin
        support = '0;
        for (int e = 0; e < ENGINES; e++) begin
            support[e] = class_uses_nts(cls_q) ? (e < ENGINES_NTS) : (e >= ENGINES_NTS);
        end
    end

    assign eligible = support & i_engine_ready & ~i_engine_busy;

    nts_rr_arbiter #(
        .N     (ENGINES),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req (eligible),
        .i_ptr (ptr_q),
        .o_gnt (arb_gnt),
        .o_idx (arb_idx),
        .o_any (arb_any)
    );

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        wait_cnt_d    = wait_cnt_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        drop_d        = 1'b0;
        grant_evt     = 1'b0;
        drop_evt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_pkt_valid) begin
                    cls_d      = i_pkt_class;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A grant beats the timeout when an engine frees up on the last wait cycle.
                if (support == '0) begin
                    drop_d   = 1'b1;
                    drop_evt = 1'b1;
                    state_d  = ST_IDLE;
                end else if (arb_any) begin
                    grant_d       = arb_gnt;
                    grant_valid_d = 1'b1;
                    grant_evt     = 1'b1;
                    ptr_d         = (arb_idx == IDX_W'(ENGINES - 1)) ? '0 : arb_idx + 1'b1;
                    state_d       = ST_GRANT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    drop_d   = 1'b1;
                    drop_evt = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_GRANT: begin
                if (i_grant_done) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q       <= ST_IDLE;
            cls_q         <= '0;
            wait_cnt_q    <= '0;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            wait_cnt_q    <= wait_cnt_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            drop_q        <= drop_d;
        end
    end

    assign o_pkt_ready   = (state_q == ST_IDLE) && !i_areset;
    assign o_pkt_drop    = drop_q;
    assign o_grant       = grant_q;
    assign o_grant_valid = grant_valid_q;

`ifdef NTS_ENGINE_SELECTOR_STATS_EN

    logic                    api_in_win;
    logic [5:0]              api_ofs;
    logic                    stats_clear;
    logic [CNT_WIDTH-1:0]    grant_cnt_q [ENGINES];
    logic [CNT_WIDTH-1:0]    grant_cnt_d [ENGINES];
    logic [CNT_WIDTH-1:0]    drop_cnt_q  [NUM_CLASSES];
    logic [CNT_WIDTH-1:0]    drop_cnt_d  [NUM_CLASSES];
    logic [API_RW_WIDTH-1:0] rdata_q, rdata_d;
    logic                    unused_wdata;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The 64-word window is assumed aligned, so the upper address bits select it.
    assign api_in_win   = (i_api_address[API_ADDR_WIDTH-1:6] == API_BASE[API_ADDR_WIDTH-1:6]);
    assign api_ofs      = i_api_address[5:0];
    assign stats_clear  = i_api_cs && i_api_we && api_in_win && (api_ofs == STATS_OFS_CLEAR);
    assign unused_wdata = ^i_api_write_data;

    always_comb begin
        for (int e = 0; e < ENGINES; e++) begin
            grant_cnt_d[e] = grant_cnt_q[e];
            if (stats_clear) begin
                grant_cnt_d[e] = '0;
            end else if (grant_evt && (arb_idx == IDX_W'(e))) begin
                grant_cnt_d[e] = sat_inc(grant_cnt_q[e]);
            end
        end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            drop_cnt_d[c] = drop_cnt_q[c];
            if (stats_clear) begin
                drop_cnt_d[c] = '0;
            end else if (drop_evt && (cls_q == 2'(c))) begin
                drop_cnt_d[c] = sat_inc(drop_cnt_q[c]);
            end
        end
        rdata_d = '0;
        if (i_api_cs && !i_api_we && api_in_win) begin
            for (int e = 0; e < ENGINES; e++) begin
                if (api_ofs == STATS_OFS_GRANT + 6'(e)) rdata_d = API_RW_WIDTH'(grant_cnt_q[e]);
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (api_ofs == STATS_OFS_DROP + 6'(c)) rdata_d = API_RW_WIDTH'(drop_cnt_q[c]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            for (int e = 0; e < ENGINES; e++) grant_cnt_q[e] <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) drop_cnt_q[c] <= '0;
            rdata_q <= '0;
        end else begin
            for (int e = 0; e < ENGINES; e++) grant_cnt_q[e] <= grant_cnt_d[e];
            for (int c = 0; c < NUM_CLASSES; c++) drop_cnt_q[c] <= drop_cnt_d[c];
            rdata_q <= rdata_d;
        end
    end

    assign o_api_read_data = rdata_q;

`else

    logic unused_api;

    assign unused_api      = ^{i_api_cs, i_api_we, i_api_address, i_api_write_data,
                               grant_evt, drop_evt};
    assign o_api_read_data = '0;

`endif

endmodule

// File: tb/tb_nts_engine_selector.sv
// Directed bench for nts_engine_selector: 2+2 engine instance with a short wait
// timeout, plus an NTS-only instance for the no-mini-engine drop path.
module tb_nts_engine_selector;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        a_valid, a_ready, a_drop, a_gv, a_done;
    logic [1:0]  a_class;
    logic [3:0]  a_busy, a_eready, a_grant;
    logic        api_cs, api_we;
    logic [11:0] api_addr;
    logic [31:0] api_wdata, api_rdata;

    logic        b_valid, b_ready, b_drop, b_gv, b_done;
    logic [1:0]  b_class;
    logic [1:0]  b_busy, b_eready, b_grant;
    logic        b_cs, b_we;
    logic [11:0] b_addr;
    logic [31:0] b_wdata, b_rdata;

    always #5 clk = ~clk;

    nts_engine_selector #(
        .ENGINES_NTS (2), .ENGINES_MINI (2), .WAIT_CYCLES (8)
    ) dut (
        .i_clk (clk), .i_areset (rst),
        .i_pkt_valid (a_valid), .i_pkt_class (a_class),
        .o_pkt_ready (a_ready), .o_pkt_drop (a_drop),
        .i_engine_busy (a_busy), .i_engine_ready (a_eready),
        .o_grant_valid (a_gv), .o_grant (a_grant), .i_grant_done (a_done),
        .i_api_cs (api_cs), .i_api_we (api_we), .i_api_address (api_addr),
        .i_api_write_data (api_wdata), .o_api_read_data (api_rdata)
    );

    nts_engine_selector #(
        .ENGINES_NTS (2), .ENGINES_MINI (0), .WAIT_CYCLES (8)
    ) dut_nts_only (
        .i_clk (clk), .i_areset (rst),
        .i_pkt_valid (b_valid), .i_pkt_class (b_class),
        .o_pkt_ready (b_ready), .o_pkt_drop (b_drop),
        .i_engine_busy (b_busy), .i_engine_ready (b_eready),
        .o_grant_valid (b_gv), .o_grant (b_grant), .i_grant_done (b_done),
        .i_api_cs (b_cs), .i_api_we (b_we), .i_api_address (b_addr),
        .i_api_write_data (b_wdata), .o_api_read_data (b_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [1:0] cls);
        a_valid = 1'b1;
        a_class = cls;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic done_a();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
    endtask

    task automatic api_read(input logic [11:0] addr, output logic [31:0] data);
        api_cs   = 1'b1;
        api_we   = 1'b0;
        api_addr = addr;
        tick();
        api_cs   = 1'b0;
        data     = api_rdata;
    endtask

    task automatic api_write(input logic [11:0] addr, input logic [31:0] data);
        api_cs    = 1'b1;
        api_we    = 1'b1;
        api_addr  = addr;
        api_wdata = data;
        tick();
        api_cs    = 1'b0;
        api_we    = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b1;
        a_valid = 0; a_class = 0; a_busy = 0; a_eready = 4'hF; a_done = 0;
        api_cs = 0; api_we = 0; api_addr = 0; api_wdata = 0;
        b_valid = 0; b_class = 0; b_busy = 0; b_eready = 2'b11; b_done = 0;
        b_cs = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tick();
        tick();
        check("rst_ready", a_ready, 0);
        check("rst_gv", a_gv, 0);
        check("rst_grant", a_grant, 0);
        check("rst_drop", a_drop, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", a_ready, 1);

        // Frame 1: NTS, all idle, pointer 0
        send_a(2'd0);
        check("t1_ready_wait", a_ready, 0);
        check("t1_no_grant_yet", a_gv, 0);
        tick();
        check("t1_grant", a_grant, 4'b0001);
        check("t1_gv", a_gv, 1);
        a_busy = 4'b0001;
        tick();
        check("t1_grant_held", a_grant, 4'b0001);
        a_busy = 4'b0000;
        done_a();
        check("t1_gv_clear", a_gv, 0);
        check("t1_grant_clear", a_grant, 0);
        check("t1_ready_back", a_ready, 1);
        send_a(2'd0);
        tick();
        check("t1_second_grant", a_grant, 4'b0010);
        done_a();

        // NET frame: engine 2 busy, only engine 3 eligible
        a_busy = 4'b0100;
        send_a(2'd3);
        tick();
        check("t2_net_grant", a_grant, 4'b1000);
        done_a();
        a_busy = 4'b0000;

        // NTP frame with engine 0 not ready
        a_eready = 4'b1110;
        send_a(2'd2);
        tick();
        check("t2_ntp_grant", a_grant, 4'b0010);
        done_a();
        a_eready = 4'hF;

        // NTP_AUTH with both mini engines busy: timeout drop
        a_busy = 4'b1100;
        send_a(2'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("t3_no_drop_early", a_drop, 0);
        end
        tick();
        check("t3_drop", a_drop, 1);
        check("t3_ready", a_ready, 1);
        check("t3_no_gv", a_gv, 0);
        tick();
        check("t3_drop_pulse", a_drop, 0);

        // Engines free up on the timeout cycle: grant wins (pointer is 2)
        send_a(2'd1);
        for (int i = 1; i < 8; i++) tick();
        a_busy = 4'b0000;
        tick();
        check("t3_edge_grant", a_grant, 4'b0100);
        check("t3_edge_no_drop", a_drop, 0);
        done_a();

        // No mini engines: NET frame drops straight away
        b_valid = 1'b1;
        b_class = 2'd3;
        tick();
        b_valid = 1'b0;
        check("t4_drop_not_yet", b_drop, 0);
        tick();
        check("t4_drop", b_drop, 1);
        check("t4_no_gv", b_gv, 0);
        check("t4_ready", b_ready, 1);
        check("t4_rdata", b_rdata, 0);

`ifdef NTS_ENGINE_SELECTOR_STATS_EN
        api_write(12'h320, 32'h1);
        a_eready = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            send_a(2'd0);
            tick();
            done_a();
        end
        a_eready = 4'b0000;
        send_a(2'd2);
        for (int i = 0; i < 8; i++) tick();
        check("t5_ntp_drop", a_drop, 1);
        a_eready = 4'hF;
        api_read(12'h301, rd);
        check("t5_grant1_cnt", rd, 3);
        tick();
        check("t5_rdata_idle", api_rdata, 0);
        api_read(12'h312, rd);
        check("t5_drop_ntp_cnt", rd, 1);
        api_read(12'h320, rd);
        check("t5_clear_reads0", rd, 0);
        api_write(12'h320, 32'h0);
        api_read(12'h301, rd);
        check("t5_grant1_cleared", rd, 0);
        api_read(12'h312, rd);
        check("t5_drop_cleared", rd, 0);
        send_a(2'd0);
        tick();
        done_a();
`else
        api_read(12'h301, rd);
        check("t5_no_stats_rdata", rd, 0);
`endif

        // Reset while a grant is held
        send_a(2'd0);
        tick();
        check("t6_gv_before", a_gv, 1);
        rst = 1'b1;
        tick();
        check("t6_gv_reset", a_gv, 0);
        check("t6_grant_reset", a_grant, 0);
        check("t6_ready_in_reset", a_ready, 0);
        rst = 1'b0;
        tick();
        send_a(2'd0);
        tick();
        check("t6_ptr_zero", a_grant, 4'b0001);
        done_a();
`ifdef NTS_ENGINE_SELECTOR_STATS_EN
        api_read(12'h301, rd);
        check("t6_cnt_reset", rd, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
